// File: rtl/hex_scan_ctrl_if.sv
// Bus between the value-producing datapath (master) and the 4-digit scan controller (slave).
// load is a single-cycle capture strobe with no back-pressure: every cycle it is high, value/dp are taken.
interface hex_scan_ctrl_if;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz_en;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        frame;
  logic [1:0]  dbg_state;

  modport master (
    output enable, value, dp, load, lz_en,
    input  seg, sel, frame, dbg_state
  );

  modport slave (
    input  enable, value, dp, load, lz_en,
    output seg, sel, frame, dbg_state
  );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Four-digit hex scanner for a shared 7-segment bus: blank-then-show slots per digit,
// shadow/display registers committed only at frame start, leading-zero blanking, decimal points.
module hex_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 1000
) (
  input  logic           clk,
  input  logic           n_rst,
  hex_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   shd_val_q, shd_val_d;
  logic [3:0]    shd_dp_q, shd_dp_d;
  logic [15:0]   dsp_val_q, dsp_val_d;
  logic [3:0]    dsp_dp_q, dsp_dp_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    sel_q, sel_d;
  logic          frame_q, frame_d;
  logic          commit;
  logic [3:0]    nib_d;
  logic          lz_hit;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hFC;
      4'h1: glyph = 8'h60;
      4'h2: glyph = 8'hDA;
      4'h3: glyph = 8'hF2;
      4'h4: glyph = 8'h66;
      4'h5: glyph = 8'hB6;
      4'h6: glyph = 8'hBE;
      4'h7: glyph = 8'hE0;
      4'h8: glyph = 8'hFE;
      4'h9: glyph = 8'hF6;
      4'hA: glyph = 8'hEE;
      4'hB: glyph = 8'h3E;
      4'hC: glyph = 8'h9C;
      4'hD: glyph = 8'h7A;
      4'hE: glyph = 8'h9E;
      default: glyph = 8'h8E;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    shd_val_d = bus.load ? bus.value : shd_val_q;
    shd_dp_d  = bus.load ? bus.dp : shd_dp_q;
    dsp_val_d = dsp_val_q;
    dsp_dp_d  = dsp_dp_q;
    commit    = 1'b0;
    if (!bus.enable) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = 2'd0;
          cnt_d   = '0;
          commit  = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            idx_d   = idx_q + 2'd1;
            commit  = (idx_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
    // A load on the commit edge goes straight to the display (bypass).
    if (commit) begin
      dsp_val_d = shd_val_d;
      dsp_dp_d  = shd_dp_d;
    end
  end

  // Outputs are computed from next-state values so the pins come straight from flops.
  always_comb begin
    nib_d = dsp_val_d[{idx_d, 2'b00} +: 4];
    case (idx_d)
      2'd3:    lz_hit = (dsp_val_d[15:12] == 4'h0);
      2'd2:    lz_hit = (dsp_val_d[15:8] == 8'h00);
      2'd1:    lz_hit = (dsp_val_d[15:4] == 12'h000);
      default: lz_hit = 1'b0;
    endcase
    sel_d = 4'hF;
    seg_d = 8'h00;
    if (state_d == ST_SHOW && !(bus.lz_en && lz_hit)) begin
      sel_d = ~(4'b0001 << idx_d);
      seg_d = glyph(nib_d) | {7'b0, dsp_dp_d[idx_d]};
    end
    frame_d = (state_d == ST_SHOW) && (idx_d == 2'd3) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      shd_val_q <= 16'h0000;
      shd_dp_q  <= 4'h0;
      dsp_val_q <= 16'h0000;
      dsp_dp_q  <= 4'h0;
      seg_q     <= 8'h00;
      sel_q     <= 4'hF;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shd_val_q <= shd_val_d;
      shd_dp_q  <= shd_dp_d;
      dsp_val_q <= dsp_val_d;
      dsp_dp_q  <= dsp_dp_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.sel       = sel_q;
  assign bus.frame     = frame_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frames).
module tb_hex_scan_ctrl;
  logic clk;
  logic n_rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [12:0] exp_q[$];

  hex_scan_ctrl_if bus ();

  hex_scan_ctrl #(
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pins();
    return {19'b0, bus.frame, bus.sel, bus.seg};
  endfunction

  // One full frame from BLANK(digit0): each digit entry is {sel, seg} during SHOW.
  task automatic run_frame(input string tag,
                           input logic [11:0] d0, input logic [11:0] d1,
                           input logic [11:0] d2, input logic [11:0] d3,
                           input int load_at, input logic [15:0] nv, input logic [3:0] ndp);
    logic [11:0] dig[4];
    logic [12:0] exp;
    dig[0] = d0; dig[1] = d1; dig[2] = d2; dig[3] = d3;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back({(s == 3 && c == 7), (c < 2) ? 12'hF00 : dig[s]});
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp = exp_q.pop_front();
      check(tag, pins(), {19'b0, exp});
      if (k == load_at) begin
        bus.value = nv;
        bus.dp    = ndp;
        bus.load  = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
    end
  endtask

  initial begin
    n_rst      = 1'b0;
    bus.enable = 1'b1;
    bus.load   = 1'b1;
    bus.value  = 16'h1234;
    bus.dp     = 4'b0001;
    bus.lz_en  = 1'b0;

    // Held in reset with enable/load active: outputs stay dark.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_pins", pins(), 32'h0000_0F00);
    end
    check("reset_state", {30'b0, bus.dbg_state}, 32'd0);

    // Release; load still high on the first edge commits 1234 by bypass.
    n_rst = 1'b1;
    run_frame("scan1234", 12'hE67, 12'hDF2, 12'hBDA, 12'h760, -1, 16'h0, 4'h0);

    // Load ABCD while digit1 shows: this frame must stay 1234.
    run_frame("no_tear", 12'hE67, 12'hDF2, 12'hBDA, 12'h760, 12, 16'hABCD, 4'b0000);

    bus.lz_en = 1'b1;
    run_frame("scanABCD", 12'hE7A, 12'hD9C, 12'hB3E, 12'h7EE, 20, 16'h0005, 4'b0000);
    run_frame("lz_0005", 12'hEB6, 12'hF00, 12'hF00, 12'hF00, 20, 16'h0000, 4'b0000);
    run_frame("lz_0000", 12'hEFC, 12'hF00, 12'hF00, 12'hF00, 20, 16'h0A05, 4'b1010);
    run_frame("lz_0A05", 12'hEB6, 12'hDFD, 12'hBEE, 12'hF00, -1, 16'h0, 4'h0);

    // Enable drop during SHOW(digit2).
    for (int i = 1; i <= 20; i++) tick();
    check("pre_drop", pins(), 32'h0000_0BEE);
    bus.enable = 1'b0;
    tick();
    check("drop_pins", pins(), 32'h0000_0F00);
    check("drop_state", {30'b0, bus.dbg_state}, 32'd0);
    bus.lz_en = 1'b0;
    bus.value = 16'h4321;
    bus.dp    = 4'b0000;
    bus.load  = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("dark_no_frame", pins(), 32'h0000_0F00);
    end
    bus.enable = 1'b1;
    run_frame("reenable", 12'hE60, 12'hDDA, 12'hBF2, 12'h766, -1, 16'h0, 4'h0);

    // Asynchronous reset pulse between edges during SHOW(digit0).
    for (int i = 1; i <= 5; i++) tick();
    check("pre_rst", pins(), 32'h0000_0E60);
    #2 n_rst = 1'b0;
    #1;
    check("async_pins", pins(), 32'h0000_0F00);
    check("async_state", {30'b0, bus.dbg_state}, 32'd0);
    #1 n_rst = 1'b1;
    run_frame("after_rst", 12'hEFC, 12'hDFC, 12'hBFC, 12'h7FC, -1, 16'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
